// File: rtl/vin_frame_packer_pkg.sv
// rtl/vin_frame_packer_pkg.sv - shared video constants and state type
// Pixel-pair geometry and FSM state shared by the frame packer and its pair packer.
package vin_frame_packer_pkg;

  localparam int PIX_PER_CLK    = 2;
  localparam int PAIRS_PER_WORD = 4;
  localparam int WORD_W         = 64;
  localparam int PAIR_W         = 8 * PIX_PER_CLK;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    FRAME     = 1'b1
  } state_e;

endpackage

// File: rtl/vin_pair_packer.sv
// rtl/vin_pair_packer.sv - packs pixel pairs into 64-bit words
// Full words leave one edge after completion; a short line is flushed when de falls.
module vin_pair_packer
  import vin_frame_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              de,
  input  logic [PAIR_W-1:0] pixel,
  input  logic              clear,
  output logic [WORD_W-1:0] word,
  output logic              valid,
  output logic              eol
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              pending_q, pending_d;
  logic              de_prev_q, de_prev_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              eol_q, eol_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      shreg_q   <= '0;
      pending_q <= 1'b0;
      de_prev_q <= 1'b0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      de_prev_q <= de_prev_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      eol_q     <= eol_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    pending_d = pending_q;
    de_prev_d = de;
    word_d    = '0;
    valid_d   = 1'b0;
    eol_d     = 1'b0;
    if (clear) begin
      cnt_d     = '0;
      shreg_d   = '0;
      pending_d = 1'b0;
    end else begin
      if (pending_q) begin
        valid_d   = 1'b1;
        eol_d     = !de;
        word_d    = shreg_q;
        pending_d = 1'b0;
      end else if (!de && de_prev_q && cnt_q != 2'd0) begin
        valid_d = 1'b1;
        eol_d   = 1'b1;
        word_d  = shreg_q;
        cnt_d   = '0;
      end
      if (de) begin
        // Slot 0 starts a fresh word so a later flush carries zeros in unused slots.
        if (cnt_q == 2'd0) shreg_d = {{(WORD_W-PAIR_W){1'b0}}, pixel};
        else               shreg_d[{cnt_q, 4'b0000} +: PAIR_W] = pixel;
        if (cnt_q == 2'(PAIRS_PER_WORD-1)) begin
          pending_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
    end
  end

  assign word  = word_q;
  assign valid = valid_q;
  assign eol   = eol_q;

endmodule

// File: rtl/vin_frame_packer.sv
// rtl/vin_frame_packer.sv - video input frame packer top level
// Vsync-framed FSM, line/width measurement, SOF tagging and per-frame overflow report.
module vin_frame_packer
  import vin_frame_packer_pkg::*;
#(
  parameter int HCNT_W = 11,
  parameter int VCNT_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_vsync,
  input  logic              v_de,
  input  logic [15:0]       v_pixel,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [63:0]       fifo_data,
  output logic              fifo_sof,
  output logic              fifo_eol,
  output logic              frame_done,
  output logic [HCNT_W:0]   h_active,
  output logic [VCNT_W-1:0] v_active,
  output logic              frame_ovf
);

  state_e              state_q, state_d;
  logic                vsync_prev_q;
  logic                abort_q, abort_d;
  logic                line_active_q, line_active_d;
  logic [HCNT_W-1:0]   hpair_q, hpair_d;
  logic [HCNT_W-1:0]   width_q, width_d;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
  logic                ovf_q, ovf_d;
  logic                sof_armed_q, sof_armed_d;
  logic                frame_done_q, frame_done_d;
  logic [HCNT_W:0]     h_active_q, h_active_d;
  logic [VCNT_W-1:0]   v_active_q, v_active_d;
  logic                frame_ovf_q, frame_ovf_d;

  logic vsync_rise, in_frame, pk_de, ovf_now;

  assign vsync_rise = v_vsync && !vsync_prev_q;
  assign in_frame   = (state_q == FRAME);
  // A line cut by vsync stays blocked until de drops, so none of its pairs are packed.
  assign pk_de      = v_de && in_frame && !abort_q && !vsync_rise;
  assign ovf_now    = ovf_q || (fifo_wr && fifo_full);

  vin_pair_packer u_pair_packer (
    .clk   (clk),
    .rst   (rst),
    .de    (pk_de),
    .pixel (v_pixel),
    .clear (vsync_rise),
    .word  (fifo_data),
    .valid (fifo_wr),
    .eol   (fifo_eol)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC_WAIT;
      vsync_prev_q  <= 1'b0;
      abort_q       <= 1'b0;
      line_active_q <= 1'b0;
      hpair_q       <= '0;
      width_q       <= '0;
      vcnt_q        <= '0;
      ovf_q         <= 1'b0;
      sof_armed_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      frame_ovf_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_prev_q  <= v_vsync;
      abort_q       <= abort_d;
      line_active_q <= line_active_d;
      hpair_q       <= hpair_d;
      width_q       <= width_d;
      vcnt_q        <= vcnt_d;
      ovf_q         <= ovf_d;
      sof_armed_q   <= sof_armed_d;
      frame_done_q  <= frame_done_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      frame_ovf_q   <= frame_ovf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    abort_d       = abort_q;
    line_active_d = line_active_q;
    hpair_d       = hpair_q;
    width_d       = width_q;
    vcnt_d        = vcnt_q;
    ovf_d         = ovf_now;
    sof_armed_d   = sof_armed_q && !fifo_wr;
    frame_done_d  = 1'b0;
    h_active_d    = h_active_q;
    v_active_d    = v_active_q;
    frame_ovf_d   = frame_ovf_q;
    if (vsync_rise) begin
      if (in_frame) begin
        frame_done_d = 1'b1;
        h_active_d   = {width_q, 1'b0};
        v_active_d   = vcnt_q;
        frame_ovf_d  = ovf_now;
      end
      state_d       = FRAME;
      sof_armed_d   = 1'b1;
      abort_d       = v_de;
      line_active_d = 1'b0;
      hpair_d       = '0;
      width_d       = '0;
      vcnt_d        = '0;
      ovf_d         = 1'b0;
    end else if (in_frame) begin
      if (v_de) begin
        if (!abort_q) begin
          line_active_d = 1'b1;
          if (hpair_q != '1) hpair_d = hpair_q + 1'b1;
        end
      end else begin
        abort_d = 1'b0;
        if (line_active_q) begin
          line_active_d = 1'b0;
          hpair_d       = '0;
          width_d       = hpair_q;
          if (vcnt_q != '1) vcnt_d = vcnt_q + 1'b1;
        end
      end
    end
  end

  assign fifo_sof   = fifo_wr && sof_armed_q;
  assign frame_done = frame_done_q;
  assign h_active   = h_active_q;
  assign v_active   = v_active_q;
  assign frame_ovf  = frame_ovf_q;

endmodule

// File: tb/tb_vin_frame_packer.sv
// tb/tb_vin_frame_packer.sv - directed self-checking bench for vin_frame_packer
// Captures every strobed word at negedge; each scenario task checks its own results.
module tb_vin_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_vsync;
  logic        v_de;
  logic [15:0] v_pixel;
  logic        fifo_full;
  logic        fifo_wr;
  logic [63:0] fifo_data;
  logic        fifo_sof;
  logic        fifo_eol;
  logic        frame_done;
  logic [11:0] h_active;
  logic [11:0] v_active;
  logic        frame_ovf;

  int tests = 0;
  int fails = 0;

  logic [63:0] wdata [256];
  logic        wsof  [256];
  logic        weol  [256];
  int          wcnt     = 0;
  int          done_cnt = 0;

  localparam logic [63:0] W_LO = 64'h0706050403020100;
  localparam logic [63:0] W_HI = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] W_PART = 64'h000000000B0A0908;

  vin_frame_packer dut (
    .clk        (clk),
    .rst        (rst),
    .v_vsync    (v_vsync),
    .v_de       (v_de),
    .v_pixel    (v_pixel),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .fifo_sof   (fifo_sof),
    .fifo_eol   (fifo_eol),
    .frame_done (frame_done),
    .h_active   (h_active),
    .v_active   (v_active),
    .frame_ovf  (frame_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr && wcnt < 256) begin
      wdata[wcnt] = fifo_data;
      wsof[wcnt]  = fifo_sof;
      weol[wcnt]  = fifo_eol;
      wcnt        = wcnt + 1;
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int n);
    for (int i = 0; i < n; i++) begin
      v_de    = 1'b1;
      v_pixel = {8'(2*i+1), 8'(2*i)};
      tick();
    end
    v_de    = 1'b0;
    v_pixel = 16'h0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic pulse_vsync();
    v_vsync = 1'b1;
    tick();
    tick();
    v_vsync = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; v_vsync = 1'b0; v_de = 1'b0; v_pixel = 16'h0; fifo_full = 1'b0;
    #3;
    tests++; if (fifo_wr !== 1'b0)    begin fails++; $display("FAIL reset_wr got %b exp 0", fifo_wr); end
    tests++; if (fifo_data !== 64'h0) begin fails++; $display("FAIL reset_data got %h exp 0", fifo_data); end
    tests++; if ({fifo_sof, fifo_eol, frame_done, frame_ovf} !== 4'b0)
      begin fails++; $display("FAIL reset_flags got %b exp 0000", {fifo_sof, fifo_eol, frame_done, frame_ovf}); end
    tests++; if ({h_active, v_active} !== 24'h0)
      begin fails++; $display("FAIL reset_meas got %h exp 0", {h_active, v_active}); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_no_sync();
    int b = wcnt;
    int d = done_cnt;
    for (int i = 0; i < 100; i++) begin
      v_de = 1'b1; v_pixel = 16'(i); tick();
    end
    v_de = 1'b0;
    tick(); tick(); tick();
    tests++; if (wcnt - b !== 0)     begin fails++; $display("FAIL nosync_writes got %0d exp 0", wcnt - b); end
    tests++; if (done_cnt - d !== 0) begin fails++; $display("FAIL nosync_done got %0d exp 0", done_cnt - d); end
  endtask

  task automatic test_basic_frame();
    int b, d;
    pulse_vsync();
    b = wcnt; d = done_cnt;
    for (int l = 0; l < 3; l++) drive_line(8);
    pulse_vsync();
    tests++; if (wcnt - b !== 6) begin fails++; $display("FAIL basic_words got %0d exp 6", wcnt - b); end
    tests++; if (wdata[b][15:0] !== 16'h0100) begin fails++; $display("FAIL basic_pair0 got %h exp 0100", wdata[b][15:0]); end
    tests++; if (wdata[b] !== W_LO)   begin fails++; $display("FAIL basic_w0 got %h exp %h", wdata[b], W_LO); end
    tests++; if (wdata[b+1] !== W_HI) begin fails++; $display("FAIL basic_w1 got %h exp %h", wdata[b+1], W_HI); end
    tests++; if ({wsof[b], wsof[b+1], wsof[b+2], wsof[b+3], wsof[b+4], wsof[b+5]} !== 6'b100000)
      begin fails++; $display("FAIL basic_sof got %b exp 100000", {wsof[b], wsof[b+1], wsof[b+2], wsof[b+3], wsof[b+4], wsof[b+5]}); end
    tests++; if ({weol[b], weol[b+1], weol[b+2], weol[b+3], weol[b+4], weol[b+5]} !== 6'b010101)
      begin fails++; $display("FAIL basic_eol got %b exp 010101", {weol[b], weol[b+1], weol[b+2], weol[b+3], weol[b+4], weol[b+5]}); end
    tests++; if (h_active !== 12'd16)  begin fails++; $display("FAIL basic_h got %0d exp 16", h_active); end
    tests++; if (v_active !== 12'd3)   begin fails++; $display("FAIL basic_v got %0d exp 3", v_active); end
    tests++; if (done_cnt - d !== 1)   begin fails++; $display("FAIL basic_done got %0d exp 1", done_cnt - d); end
    tests++; if (frame_ovf !== 1'b0)   begin fails++; $display("FAIL basic_ovf got %b exp 0", frame_ovf); end
  endtask

  task automatic test_partial_line();
    int b = wcnt;
    drive_line(6);
    pulse_vsync();
    tests++; if (wcnt - b !== 2) begin fails++; $display("FAIL part_words got %0d exp 2", wcnt - b); end
    tests++; if (wdata[b] !== W_LO || weol[b] !== 1'b0 || wsof[b] !== 1'b1)
      begin fails++; $display("FAIL part_w0 got %h eol %b sof %b exp %h eol 0 sof 1", wdata[b], weol[b], wsof[b], W_LO); end
    tests++; if (wdata[b+1] !== W_PART || weol[b+1] !== 1'b1)
      begin fails++; $display("FAIL part_w1 got %h eol %b exp %h eol 1", wdata[b+1], weol[b+1], W_PART); end
    tests++; if (h_active !== 12'd12) begin fails++; $display("FAIL part_h got %0d exp 12", h_active); end
  endtask

  task automatic test_exact_word();
    int b = wcnt;
    drive_line(4);
    pulse_vsync();
    tests++; if (wcnt - b !== 1) begin fails++; $display("FAIL exact_words got %0d exp 1", wcnt - b); end
    tests++; if (wdata[b] !== W_LO || weol[b] !== 1'b1)
      begin fails++; $display("FAIL exact_w0 got %h eol %b exp %h eol 1", wdata[b], weol[b], W_LO); end
    tests++; if (h_active !== 12'd8 || v_active !== 12'd1)
      begin fails++; $display("FAIL exact_meas got h %0d v %0d exp h 8 v 1", h_active, v_active); end
  endtask

  task automatic test_overflow();
    int b = wcnt;
    fifo_full = 1'b1;
    drive_line(4);
    fifo_full = 1'b0;
    pulse_vsync();
    tests++; if (wcnt - b !== 1)    begin fails++; $display("FAIL ovf_words got %0d exp 1", wcnt - b); end
    tests++; if (frame_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", frame_ovf); end
    drive_line(4);
    pulse_vsync();
    tests++; if (frame_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clean got %b exp 0", frame_ovf); end
  endtask

  task automatic test_abort();
    int b, b2;
    b = wcnt;
    drive_line(8);
    for (int i = 0; i < 2; i++) begin
      v_de = 1'b1; v_pixel = {8'(2*i+1), 8'(2*i)}; tick();
    end
    v_vsync = 1'b1; v_pixel = 16'hAAAA; tick();
    v_pixel = 16'hBBBB; tick();
    v_de = 1'b0; v_vsync = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tests++; if (wcnt - b !== 2) begin fails++; $display("FAIL abort_words got %0d exp 2", wcnt - b); end
    tests++; if (h_active !== 12'd16 || v_active !== 12'd1)
      begin fails++; $display("FAIL abort_meas got h %0d v %0d exp h 16 v 1", h_active, v_active); end
    b2 = wcnt;
    drive_line(4);
    pulse_vsync();
    tests++; if (wcnt - b2 !== 1 || wsof[b2] !== 1'b1 || wdata[b2] !== W_LO)
      begin fails++; $display("FAIL abort_next got n %0d sof %b data %h exp n 1 sof 1 data %h", wcnt - b2, wsof[b2], wdata[b2], W_LO); end
    tests++; if (v_active !== 12'd1 || h_active !== 12'd8)
      begin fails++; $display("FAIL abort_next_meas got h %0d v %0d exp h 8 v 1", h_active, v_active); end
  endtask

  task automatic test_reset_mid();
    int b;
    for (int i = 0; i < 5; i++) begin
      v_de = 1'b1; v_pixel = {8'(2*i+1), 8'(2*i)}; tick();
    end
    tests++; if (fifo_wr !== 1'b1) begin fails++; $display("FAIL mid_wr_before got %b exp 1", fifo_wr); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({fifo_wr, fifo_sof, fifo_eol, frame_done, frame_ovf} !== 5'b0 || fifo_data !== 64'h0)
      begin fails++; $display("FAIL mid_rst_out got %b data %h exp 0", {fifo_wr, fifo_sof, fifo_eol, frame_done, frame_ovf}, fifo_data); end
    tests++; if (h_active !== 12'd0 || v_active !== 12'd0)
      begin fails++; $display("FAIL mid_rst_meas got h %0d v %0d exp 0", h_active, v_active); end
    tick();
    rst = 1'b0; v_de = 1'b0;
    tick();
    b = wcnt;
    drive_line(8);
    tests++; if (wcnt - b !== 0) begin fails++; $display("FAIL mid_after_writes got %0d exp 0", wcnt - b); end
  endtask

  initial begin
    test_reset();
    test_no_sync();
    test_basic_frame();
    test_partial_line();
    test_exact_word();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
